parity_frame_tx: RTL

- Serial transmitter directly downstream of the 8-bit even-parity generator.
- Accepts the generator's 9-bit word {data[7:0], parity} over a valid/ready handshake.
- Shifts the word out on a single line as a framed character: start bit, 8 data bits LSB-first, parity bit, stop bit.
- Bit timing comes from an internal clocks-per-bit counter. It also flags words whose parity bit is not even parity of the data, as a consistency check on the upstream stage.

---
 rtl/parity_frame_tx_if.sv | 14 +
 rtl/parity_frame_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/parity_frame_tx_if.sv
// rtl/parity_frame_tx_if.sv - word handshake between the parity generator and the frame transmitter
// Ports (signals):
//   din[8:0]   {data[7:0], even-parity bit}
//   din_valid  producer has a word
//   din_ready  transmitter can take a word this cycle
// Modports: master = producer, slave = transmitter.
interface parity_frame_tx_if;
    logic [8:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - framed serial transmitter for 9-bit {data, parity} words
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   s           word handshake (slave side): din, din_valid, din_ready
//   tx          serial line, idle high: start, data LSB-first, parity, stop
//   busy        frame in progress
//   frame_done  one-cycle pulse on the first idle cycle after the stop bit
//   parity_err  one-cycle pulse after accepting a word whose parity bit is not even parity
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_frame_tx_if.slave      s,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  parity_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] baud_cnt, baud_nx;
    logic [2:0]    bit_idx, idx_nx;
    logic [8:0]    shreg, sh_nx;
    logic          tx_nx, done_nx, perr_nx;
    logic          bit_end, xfer;

    assign s.din_ready = (state == IDLE);
    assign xfer        = s.din_valid && s.din_ready;
    assign bit_end     = (baud_cnt == LAST);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nx;
            baud_cnt   <= baud_nx;
            bit_idx    <= idx_nx;
            shreg      <= sh_nx;
            tx         <= tx_nx;
            frame_done <= done_nx;
            parity_err <= perr_nx;
        end
    end

    // tx is computed one cycle ahead and registered, so the line only
    // changes on the same edge that starts the next bit.
    always_comb begin
        state_nx = state;
        baud_nx  = '0;
        idx_nx   = bit_idx;
        sh_nx    = shreg;
        tx_nx    = tx;
        done_nx  = 1'b0;
        perr_nx  = 1'b0;

        if (state != IDLE) begin
            baud_nx = bit_end ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (xfer) begin
                    state_nx = START;
                    sh_nx    = s.din;
                    tx_nx    = 1'b0;
                    perr_nx  = s.din[0] ^ (^s.din[8:1]);
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    idx_nx   = 3'd0;
                    tx_nx    = shreg[1];
                end
            end
            DATA: begin
                // Data bits sit in shreg[8:1]; shifting right keeps the next
                // bit at shreg[2] while the parity bit stays in shreg[0].
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nx = PARITY;
                        tx_nx    = shreg[0];
                    end else begin
                        idx_nx = bit_idx + 3'd1;
                        sh_nx  = {1'b0, shreg[8:2], shreg[0]};
                        tx_nx  = shreg[2];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end
endmodule
